// File: rtl/trdb_packet_arbiter.sv
// Round-robin arbiter that buffers one trace packet and streams it out word by word.
// Optional header word before the payload when TRDB_ARB_HEADER_EN is defined.
module trdb_packet_arbiter #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned PKT_LEN = 128,
    parameter int unsigned LEN_W   = 7,
    parameter int unsigned WORD_W  = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [NUM_SRC-1:0]           req_valid_i,
    input  logic [NUM_SRC*PKT_LEN-1:0]   req_bits_i,
    input  logic [NUM_SRC*LEN_W-1:0]     req_len_i,
    output logic [NUM_SRC-1:0]           req_ready_o,
    output logic                         out_valid_o,
    output logic [WORD_W-1:0]            out_data_o,
    output logic [$clog2(NUM_SRC)-1:0]   out_src_o,
    output logic                         out_last_o,
    input  logic                         out_ready_i,
    output logic                         busy_o
);

    localparam int unsigned SRC_W = $clog2(NUM_SRC);
    localparam int unsigned CNT_W = LEN_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SRC_W-1:0]   r_rr_ptr;
    logic [PKT_LEN-1:0] r_buf;
    logic [CNT_W-1:0]   r_cnt;
    logic [SRC_W-1:0]   r_src;
`ifdef TRDB_ARB_HEADER_EN
    logic [7:0]         r_len;
    logic [WORD_W-1:0]  w_hdr;
`endif

    logic               w_any;
    logic [SRC_W-1:0]   w_grant;
    logic [SRC_W-1:0]   w_idx;
    logic               w_take;
    logic               w_hs;
    logic [PKT_LEN-1:0] w_sel_bits;
    logic [LEN_W-1:0]   w_sel_len;
    logic [CNT_W-1:0]   w_len_clip;
    logic [CNT_W-1:0]   w_nwords;
    logic [PKT_LEN-1:0] w_masked;

    // First pending source at or after the round-robin pointer.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            w_idx = SRC_W'((32'(r_rr_ptr) + k) % NUM_SRC);
            if (!w_any && req_valid_i[w_idx]) begin
                w_any   = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_comb begin
        w_sel_bits = '0;
        w_sel_len  = '0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (SRC_W'(s) == w_grant) begin
                w_sel_bits = req_bits_i[s*PKT_LEN +: PKT_LEN];
                w_sel_len  = req_len_i[s*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        w_len_clip = (32'(w_sel_len) > PKT_LEN) ? CNT_W'(PKT_LEN) : CNT_W'(w_sel_len);
        w_nwords   = CNT_W'((32'(w_len_clip) + WORD_W - 1) / WORD_W);
        w_masked   = '0;
        for (int unsigned i = 0; i < PKT_LEN; i++) begin
            w_masked[i] = w_sel_bits[i] & (i < 32'(w_len_clip));
        end
    end

    assign w_take = (r_state == IDLE) && w_any && !flush_i;
    assign w_hs   = (r_state != IDLE) && out_ready_i;

`ifdef TRDB_ARB_HEADER_EN
    always_comb begin
        w_hdr       = '0;
        w_hdr[7:0]  = r_len;
        w_hdr[15:8] = 8'(r_src);
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = '0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_last_o  = 1'b0;
        busy_o      = (r_state != IDLE);
        out_src_o   = r_src;

        if (w_take) begin
            req_ready_o[w_grant] = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (w_take && (w_len_clip != '0)) begin
`ifdef TRDB_ARB_HEADER_EN
                    w_state_nxt = HDR;
`else
                    w_state_nxt = SEND;
`endif
                end
            end
`ifdef TRDB_ARB_HEADER_EN
            HDR: begin
                out_valid_o = 1'b1;
                out_data_o  = w_hdr;
                if (w_hs) begin
                    w_state_nxt = SEND;
                end
            end
`endif
            SEND: begin
                out_valid_o = 1'b1;
                out_data_o  = r_buf[WORD_W-1:0];
                out_last_o  = (r_cnt == CNT_W'(1));
                if (w_hs && (r_cnt == CNT_W'(1))) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Abort wins over every transition, including a grant in IDLE.
        if (flush_i) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
            r_buf    <= '0;
            r_cnt    <= '0;
            r_src    <= '0;
`ifdef TRDB_ARB_HEADER_EN
            r_len    <= '0;
`endif
        end else if (flush_i) begin
            r_cnt <= '0;
        end else if (w_take) begin
            r_rr_ptr <= SRC_W'((32'(w_grant) + 1) % NUM_SRC);
            if (w_len_clip != '0) begin
                r_buf <= w_masked;
                r_cnt <= w_nwords;
                r_src <= w_grant;
`ifdef TRDB_ARB_HEADER_EN
                r_len <= 8'(w_len_clip);
`endif
            end
        end else if ((r_state == SEND) && w_hs) begin
            r_buf <= r_buf >> WORD_W;
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_trdb_packet_arbiter.sv
// Self-checking bench for trdb_packet_arbiter: scoreboard of expected output words
// filled at accept time and drained by a monitor on the opposite clock edge.
module tb_trdb_packet_arbiter;

    localparam int NUM_SRC = 2;
    localparam int PKT_LEN = 128;
    localparam int LEN_W   = 8;
    localparam int WORD_W  = 32;

    logic                       clk = 1'b0;
    logic                       rst_ni = 1'b0;
    logic                       flush = 1'b0;
    logic [NUM_SRC-1:0]         req_valid = '0;
    logic [NUM_SRC*PKT_LEN-1:0] req_bits = '0;
    logic [NUM_SRC*LEN_W-1:0]   req_len = '0;
    logic [NUM_SRC-1:0]         req_ready;
    logic                       out_valid;
    logic [WORD_W-1:0]          out_data;
    logic                       out_src;
    logic                       out_last;
    logic                       out_ready = 1'b1;
    logic                       busy;

    trdb_packet_arbiter #(
        .NUM_SRC(NUM_SRC), .PKT_LEN(PKT_LEN), .LEN_W(LEN_W), .WORD_W(WORD_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
        .req_valid_i(req_valid), .req_bits_i(req_bits), .req_len_i(req_len),
        .req_ready_o(req_ready), .out_valid_o(out_valid), .out_data_o(out_data),
        .out_src_o(out_src), .out_last_o(out_last), .out_ready_i(out_ready),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WORD_W-1:0] d;
        logic              last;
        logic              src;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests_run = 0;
    int   tests_failed = 0;
    logic prev_last_hs = 1'b0;

    task automatic push_exp(input int src, input logic [PKT_LEN-1:0] bits, input int len);
        int l;
        int nw;
        logic [PKT_LEN-1:0] m;
        exp_t e;
        l = (len > PKT_LEN) ? PKT_LEN : len;
        if (l == 0) return;
        m = '0;
        for (int i = 0; i < l; i++) m[i] = bits[i];
        nw = (l + WORD_W - 1) / WORD_W;
`ifdef TRDB_ARB_HEADER_EN
        e.d = {16'h0, 8'(src), 8'(l)};
        e.last = 1'b0;
        e.src = src[0];
        sb.push_back(e);
`endif
        for (int w = 0; w < nw; w++) begin
            e.d = m[w*WORD_W +: WORD_W];
            e.last = (w == nw - 1);
            e.src = src[0];
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_ni) begin
            if (prev_last_hs) begin
                tests_run++;
                if (out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL idle_gap: out_valid=%b after last word, required 0", out_valid);
                end
            end
            if (busy === 1'b1) begin
                tests_run++;
                if (req_ready !== '0) begin
                    tests_failed++;
                    $display("FAIL grant_while_busy: req_ready=%b, required 00", req_ready);
                end
            end
            prev_last_hs = 1'b0;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_word: data=%h last=%b src=%0d, none expected",
                             out_data, out_last, out_src);
                end else begin
                    mon_e = sb.pop_front();
                    if (out_data !== mon_e.d || out_last !== mon_e.last || out_src !== mon_e.src) begin
                        tests_failed++;
                        $display("FAIL word: got data=%h last=%b src=%0d, required data=%h last=%b src=%0d",
                                 out_data, out_last, out_src, mon_e.d, mon_e.last, mon_e.src);
                    end
                end
                prev_last_hs = out_last;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int src, input logic [PKT_LEN-1:0] bits, input int len);
        logic acc;
        req_bits[src*PKT_LEN +: PKT_LEN] = bits;
        req_len[src*LEN_W +: LEN_W] = LEN_W'(len);
        req_valid[src] = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 100 && !acc; c++) begin
            @(negedge clk);
            if (req_ready !== '0) acc = 1'b1;
        end
        tests_run++;
        if (!acc) begin
            tests_failed++;
            $display("FAIL accept_timeout: src=%0d never saw req_ready", src);
        end else if (req_ready !== NUM_SRC'(1 << src)) begin
            tests_failed++;
            $display("FAIL accept_onehot: req_ready=%b, required %b", req_ready, NUM_SRC'(1 << src));
        end
        if (acc) push_exp(src, bits, len);
        tick();
        req_valid[src] = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while (sb.size() != 0 && c < 300) begin
            @(negedge clk);
            c++;
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL drain_%s: %0d words outstanding, required 0", name, sb.size());
        end
        sb.delete();
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({req_ready, out_valid, out_data, out_src, out_last, busy} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: rdy=%b vld=%b data=%h src=%0d last=%b busy=%b, required all 0",
                     req_ready, out_valid, out_data, out_src, out_last, busy);
        end
        tick();
        rst_ni = 1'b1;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset: vld=%b busy=%b, required 0 0", out_valid, busy);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int rem[2];
        int order[$];
        int g;
        logic [PKT_LEN-1:0] b0;
        logic [PKT_LEN-1:0] b1;
        b0 = 128'h1111_1111;
        b1 = 128'h2222_2222;
        rem[0] = 2;
        rem[1] = 2;
        req_bits = {b1, b0};
        req_len = {8'd32, 8'd32};
        req_valid = 2'b11;
        for (int c = 0; c < 100 && (rem[0] + rem[1]) > 0; c++) begin
            @(negedge clk);
            if (req_ready !== '0) begin
                g = (req_ready[1] === 1'b1) ? 1 : 0;
                order.push_back(g);
                push_exp(g, (g == 1) ? b1 : b0, 32);
                rem[g]--;
            end
            tick();
            req_valid[0] = (rem[0] > 0);
            req_valid[1] = (rem[1] > 0);
        end
        req_valid = '0;
        tests_run++;
        if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
            tests_failed++;
            $display("FAIL rr_order: got %p, required '{0,1,0,1}", order);
        end
        wait_drain("rr");
    endtask

    task automatic test_single();
        logic [WORD_W-1:0] first;
`ifdef TRDB_ARB_HEADER_EN
        first = 32'h0000_0028;
`else
        first = 32'h1234_5678;
`endif
        issue(0, 128'hAB_1234_5678, 40);
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== first || out_src !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_word_latency: vld=%b data=%h src=%0d, required 1 %h 0",
                     out_valid, out_data, out_src, first);
        end
        wait_drain("single");
    endtask

    task automatic test_backpressure();
        logic [WORD_W-1:0] first;
`ifdef TRDB_ARB_HEADER_EN
        first = 32'h0000_0140;
`else
        first = 32'hDEAD_BEEF;
`endif
        out_ready = 1'b0;
        issue(1, 128'hCAFE_BABE_DEAD_BEEF, 64);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== first || out_last !== 1'b0 ||
                out_src !== 1'b1 || req_ready !== '0) begin
                tests_failed++;
                $display("FAIL backpressure_hold%0d: vld=%b data=%h last=%b src=%0d rdy=%b, required 1 %h 0 1 00",
                         c, out_valid, out_data, out_last, out_src, req_ready, first);
            end
            tick();
        end
        out_ready = 1'b1;
        wait_drain("bp");
    endtask

    task automatic test_zero_len();
        issue(0, 128'hFFFF_FFFF, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL zero_len_drop%0d: vld=%b busy=%b, required 0 0", c, out_valid, busy);
            end
            tick();
        end
        issue(1, 128'h55, 8);
        wait_drain("zero");
    endtask

    task automatic test_flush();
        int left;
`ifdef TRDB_ARB_HEADER_EN
        left = 3;
`else
        left = 2;
`endif
        issue(0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128);
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        out_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        tests_run++;
        if (sb.size() != left || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_pre: outstanding=%0d vld=%b, required %0d 1", sb.size(), out_valid, left);
        end
        sb.delete();
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_abort: vld=%b busy=%b last=%b, required 0 0 0", out_valid, busy, out_last);
        end
        tick();
        issue(1, 128'h600D_F00D, 32);
        wait_drain("flush");
    endtask

    task automatic test_mask_clip();
        logic [PKT_LEN-1:0] ones;
        ones = '1;
        issue(1, ones, 33);
        issue(0, ones, 200);
        issue(1, ones, 127);
        wait_drain("mask");
    endtask

`ifdef TRDB_ARB_HEADER_EN
    task automatic test_header();
        issue(1, 128'hAB_1234_5678, 40);
        @(negedge clk);
        tests_run++;
        if (out_data !== 32'h0000_0128 || out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL header_word: data=%h last=%b, required 00000128 0", out_data, out_last);
        end
        wait_drain("hdr");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_zero_len();
        test_flush();
        test_mask_clip();
`ifdef TRDB_ARB_HEADER_EN
        test_header();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
